fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues in-order requests to instruction memory,
//  buffers returned words and presents them with a valid/ready handshake to decode. The
//  decode stage takes id_instr[6:0] as its opcode. Branch/jump redirects from execute
//  flush all in-flight and buffered fetches.
// PARAMETERS
//  XLEN       32        address/data width
//  RESET_PC   32'h0     PC value loaded on reset
//  BUF_DEPTH  2         instruction buffer entries (power of 2, >=2); also the max in-flight credit
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_addr       out  XLEN  word-aligned fetch address
//  imem_rsp_valid  in   1     response valid (in order, >=1 cycle after accept, never back-pressured)
//  imem_rdata      in   32    instruction word
//  redirect_valid  in   1     taken branch/jump from execute
//  redirect_pc     in   XLEN  target; bits[1:0] ignored (forced 0)
//  id_valid        out  1     id_instr/id_pc valid
//  id_ready        in   1     decode accepts
//  id_instr        out  32    instruction (bits[6:0] = op to decoder)
//  id_pc           out  XLEN  PC of id_instr
// BEHAVIOUR
//  Reset (async assert, sync deassert): pc=RESET_PC, buffer empty, inflight=0, drop=0;
//   imem_req_valid=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h00000013 (NOP), id_pc=0.
//  Issue: imem_req_valid=1 when !redirect_valid && inflight+count < BUF_DEPTH. imem_addr=pc.
//   On accept, pc<=pc+4 (wraps mod 2^XLEN), inflight++. Buffer can never overflow.
//  Response: if drop>0, discard word and drop--; else push {pc_of_req, rdata} into buffer.
//   Request PC travels in a side queue of depth BUF_DEPTH, or is recomputed; implementer's choice.
//  Output: id_* shows buffer head, combinational from buffer; pop on id_valid && id_ready.
//   Push and pop in same cycle allowed at any occupancy incl. full. Empty -> id_valid=0.
//  Redirect (highest priority, single cycle): pc<=redirect_pc&~3; buffer flushed; drop<=inflight
//   minus any response accepted this cycle as dropped; id_valid=0 next cycle;
//   no request issued that cycle. Response arriving in the redirect cycle is discarded.
//   Back-to-back redirects: last one wins; drop accumulates correctly.
//  Latency: redirect -> first imem_req_valid next cycle; response -> id_valid next cycle.
//  Reset mid-operation: all state cleared immediately; outstanding imem responses after
//   reset deassertion are not tracked (memory side also resets).
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs perf_fetched[31:0] (words delivered to decode,
//   counts id_valid&&id_ready) and perf_flushed[31:0] (words discarded: buffer flush +
//   dropped responses); both reset 0, saturate at all-ones. Undefined: ports and logic absent.
// STRUCTURE
//  riscv_pkg: XLEN, NOP_INSTR=32'h00000013, opcode localparams (OP_LOAD 0000011,
//   OP_STORE 0100011, OP_R 0110011, OP_I 0010011, OP_BRANCH 1100011, OP_JAL 1101111,
//   OP_JALR 1100111, OP_LUI 0110111, OP_AUIPC 0010111), fetch_entry_t {pc, instr}.
//  Sub-module: fetch_buf (sync FIFO, flush input, count output) instantiated once.
// TESTING
//  1 Reset, imem 1-cycle latency, id_ready=1: addrs 0,4,8,...; id_pc follows, one instr/cycle.
//  2 id_ready=0 for 10 cycles: request stops at inflight+count=2; no loss, order kept on release.
//  3 redirect_valid with redirect_pc=32'h103 while 2 in flight: next imem_addr=32'h100,
//    both stale responses dropped, first id_pc=32'h100.
//  4 Redirect coincident with response and with id pop: response dropped, id_valid=0 next cycle.
//  5 pc=32'hFFFFFFFC fetch: next imem_addr=0 (wrap).
//  6 rst_n low mid-stream: outputs at reset values asynchronously; resume from RESET_PC;
//    with FETCH_PERF_EN check perf_fetched/perf_flushed values after scenario 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: widths, NOP, major opcodes, buffer entry type,
// and a saturating add used by the optional performance counters.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO for fetched words. Flush empties it in one cycle; push and
// pop may coincide at any occupancy, including full.
module fetch_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  // Storage write; a flush cycle never stores.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a
// credit limit of BUF_DEPTH, buffers returned words, hands them to decode.
// Redirects flush the buffer and turn every outstanding response into a drop.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_stage import riscv_pkg::*; #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);
  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);

  logic [XLEN-1:0] pc;        // next address to request
  logic [XLEN-1:0] rsp_pc;    // PC belonging to the next kept response
  logic [CW-1:0]   inflight;  // all outstanding requests, stale ones included
  logic [CW-1:0]   drop;      // outstanding responses to discard
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            run;       // holds req_valid low for the first cycle out of reset
  logic            accept, keep, pop, empty;
  logic [XLEN-1:0] tgt;
  fetch_entry_t    wr_entry, head;

  assign tgt            = redirect_pc & ~XLEN'(3);
  assign occ            = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = run && !redirect_valid && (occ < DEPTH_C);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign keep           = imem_rsp_valid && !redirect_valid && (drop == '0);

  assign wr_entry.pc    = rsp_pc;
  assign wr_entry.instr = imem_rdata;

  assign id_valid = !empty;
  assign pop      = id_valid && id_ready;
  assign id_instr = empty ? NOP_INSTR : head.instr;
  assign id_pc    = empty ? '0 : head.pc;

  fetch_buf #(.W($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (keep),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  // PC, response PC and credit/drop bookkeeping; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc       <= tgt;
        rsp_pc   <= tgt;
        inflight <= inflight - CW'(imem_rsp_valid);
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (accept) pc     <= pc + XLEN'(4);
        if (keep)   rsp_pc <= rsp_pc + XLEN'(4);
        inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] flush_inc;

  // Words lost this cycle: unpopped buffer contents plus any discarded response.
  always_comb begin
    flush_inc = '0;
    if (redirect_valid)
      flush_inc = 32'(count) - 32'(pop) + 32'(imem_rsp_valid);
    else if (imem_rsp_valid && drop != '0)
      flush_inc = 32'd1;
  end

  // Saturating delivery / discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= sat_add32(perf_fetched, 32'(pop));
      perf_flushed <= sat_add32(perf_flushed, flush_inc);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: randomized imem latency / back-pressure,
// random redirects, directed corner scenarios. Expected streams come from the
// program-order rule (target, target+4, ...) and a simple memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t mq[$];
  exp_t  exp_q[$];
  int    vectors = 0, errors = 0;
  int    cyc = 0;
  int    lat_lo = 1, lat_hi = 1;
  bit    mem_hold = 0, rdy_rand = 0;
  logic [31:0] req_exp;
  bit    redir_prev = 0;
  int    n_deliv = 0, n_rsp = 0;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_1013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: condition not reached within bound", nm);
  endtask

  task automatic seed(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] p;
      p = t + 32'(4 * i);
      exp_q.push_back('{p, memf(p)});
    end
    req_exp = t;
  endtask

  // memory responder: in order, latency >= 1, never back-pressured
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
      end else begin
        imem_req_ready = mem_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rdata     = memf(mq[0].addr);
          void'(mq.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rdata     = $urandom;
        end
      end
    end
  end

  // monitor: samples on the falling edge, pops the scoreboard on each delivery
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seed(32'h0);
        redir_prev = 0;
        n_deliv    = 0;
        n_rsp      = 0;
      end else begin
        if (redir_prev) chk("id_valid_after_redirect", 64'(id_valid), 64'd0);
        if (imem_req_valid && imem_req_ready) begin
          chk("imem_addr", 64'(imem_addr), 64'(req_exp));
          req_exp = req_exp + 32'd4;
          mq.push_back('{imem_addr, cyc + int'($urandom_range(lat_lo, lat_hi))});
        end
        if (imem_rsp_valid) n_rsp++;
        if (id_valid && id_ready) begin
          n_deliv++;
          if (exp_q.size() == 0) fail_msg("unexpected_delivery");
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("id_pc", 64'(id_pc), 64'(e.pc));
            chk("id_instr", 64'(id_instr), 64'(e.instr));
          end
        end
        if (redirect_valid) begin
          chk("req_valid_in_redirect", 64'(imem_req_valid), 64'd0);
          seed(redirect_pc & ~32'h3);
        end
        redir_prev = redirect_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_addr"},      64'(imem_addr),      64'd0);
    chk({tag, "_id_valid"},  64'(id_valid),       64'd0);
    chk({tag, "_id_instr"},  64'(id_instr),       64'h13);
    chk({tag, "_id_pc"},     64'(id_pc),          64'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetched"}, 64'(perf_fetched), 64'd0);
    chk({tag, "_perf_flushed"}, 64'(perf_flushed), 64'd0);
`endif
  endtask

  // stimulus
  initial begin
    bit found;
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12 chk_reset_outputs("reset");
    @(posedge clk); #3 rst_n = 1'b1;

    // 1: streaming, 1-cycle memory
    id_ready = 1'b1;
    repeat (30) step();

    // 2: decode stall; requests must stop at full credit
    id_ready = 1'b0;
    repeat (10) step();
    #1 chk("req_stalled", 64'(imem_req_valid), 64'd0);
    id_ready = 1'b1;
    repeat (20) step();

    // 3: redirect to 0x103 with two requests outstanding
    lat_lo = 4; lat_hi = 4;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(); #1;
      if (mq.size() == 2 && !imem_rsp_valid) found = 1;
    end
    if (!found) fail_msg("two_in_flight");
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step(); redirect_valid = 1'b0;
    #1 chk("addr_after_redirect", 64'(imem_addr), 64'h100);
    repeat (30) step();

    // drain to a quiet point, then check discard / delivery accounting
    mem_hold = 1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(); #1;
      if (mq.size() == 0 && !imem_rsp_valid && !id_valid) found = 1;
    end
    if (!found) fail_msg("drain");
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 64'(perf_fetched), 64'(n_deliv));
    chk("perf_flushed", 64'(perf_flushed), 64'(n_rsp - n_deliv));
`endif

    // redirect from idle: request with the new PC on the very next cycle
    step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); redirect_valid = 1'b0;
    #1 chk("idle_redirect_req_valid", 64'(imem_req_valid), 64'd1);
    chk("idle_redirect_addr", 64'(imem_addr), 64'h200);
    mem_hold = 0;
    repeat (10) step();

    // 4: redirect coincident with a response and a decode pop
    lat_lo = 1; lat_hi = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(); #1;
      if (imem_rsp_valid && id_valid) found = 1;
    end
    if (!found) fail_msg("rsp_pop_coincide");
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); redirect_valid = 1'b0;
    repeat (20) step();

    // 5: PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    repeat (25) step();

    // random traffic
    rdy_rand = 1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      step();
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
    end
    redirect_valid = 1'b0;
    rdy_rand = 0; lat_lo = 1; lat_hi = 2; id_ready = 1'b1;
    repeat (20) step();

    // 6: asynchronous reset mid-stream, then resume from RESET_PC
    step(); #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    step(); step(); #2 rst_n = 1'b1;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
